seq_chunk_adder_ctrl: RTL and testbench

- Multi-cycle controller that computes a WIDTH-bit add by sequencing one narrow CHUNK-bit ripple adder slice over WIDTH/CHUNK cycles, LSB chunk first.
- A registered carry links the chunks.
- Sits between a valid/ready producer and a valid/ready consumer. It trades latency for adder area in the arithmetic datapath.

---
 rtl/seq_chunk_adder_ctrl.sv | 144 ++++++++++++++
 tb/tb_seq_chunk_adder_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/seq_chunk_adder_ctrl.sv
// Multi-cycle WIDTH-bit adder built from one CHUNK-bit slice, used LSB chunk first,
// with a registered carry between chunks and valid/ready handshakes on both sides.
module seq_chunk_adder_ctrl #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CHUNK_SAFE = (CHUNK < 1) ? 1 : CHUNK;
  localparam int NCHUNK     = WIDTH / CHUNK_SAFE;
  localparam int IW         = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if ((CHUNK < 1) || (WIDTH < 1) || ((WIDTH % CHUNK_SAFE) != 0)) begin : g_bad_params
    $error("seq_chunk_adder_ctrl: WIDTH must be a positive multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [IW-1:0]    idx_r, idx_s;
  logic             carry_r, carry_s;
  logic [WIDTH-1:0] a_r, a_s;
  logic [WIDTH-1:0] b_r, b_s;
  logic [WIDTH-1:0] sum_r, sum_s;
  logic             cout_r, cout_s;
  logic             overflow_r, overflow_s;
  logic             in_ready_r, in_ready_s;
  logic             out_valid_r, out_valid_s;

  logic [CHUNK_SAFE-1:0] a_chunk_s, b_chunk_s;
  logic [CHUNK_SAFE:0]   slice_s;
  logic                  msb_cin_s;
  logic                  last_s;

  // Slice adder on the currently selected chunk of the captured operands.
  always_comb begin
    a_chunk_s = a_r[idx_r*CHUNK_SAFE +: CHUNK_SAFE];
    b_chunk_s = b_r[idx_r*CHUNK_SAFE +: CHUNK_SAFE];
    slice_s   = {1'b0, a_chunk_s} + {1'b0, b_chunk_s} + {{CHUNK_SAFE{1'b0}}, carry_r};
    // Carry into the slice MSB recovered from its sum bit and operand bits.
    msb_cin_s = a_chunk_s[CHUNK_SAFE-1] ^ b_chunk_s[CHUNK_SAFE-1] ^ slice_s[CHUNK_SAFE-1];
    last_s    = (idx_r == IW'(NCHUNK - 1));
  end

  // Next-state and next-output logic for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_s    = state_r;
    idx_s      = idx_r;
    carry_s    = carry_r;
    a_s        = a_r;
    b_s        = b_r;
    sum_s      = sum_r;
    cout_s     = cout_r;
    overflow_s = overflow_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          a_s     = a;
          b_s     = b;
          carry_s = cin;
          idx_s   = {IW{1'b0}};
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        sum_s[idx_r*CHUNK_SAFE +: CHUNK_SAFE] = slice_s[CHUNK_SAFE-1:0];
        carry_s = slice_s[CHUNK_SAFE];
        if (last_s) begin
          cout_s     = slice_s[CHUNK_SAFE];
          overflow_s = msb_cin_s ^ slice_s[CHUNK_SAFE];
          state_s    = ST_DONE;
        end else begin
          idx_s   = idx_r + IW'(1'b1);
          state_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    // Handshake flags are registered copies of the state being entered.
    in_ready_s  = (state_s == ST_IDLE);
    out_valid_s = (state_s == ST_DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      idx_r       <= {IW{1'b0}};
      carry_r     <= 1'b0;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      sum_r       <= {WIDTH{1'b0}};
      cout_r      <= 1'b0;
      overflow_r  <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      idx_r       <= idx_s;
      carry_r     <= carry_s;
      a_r         <= a_s;
      b_r         <= b_s;
      sum_r       <= sum_s;
      cout_r      <= cout_s;
      overflow_r  <= overflow_s;
      in_ready_r  <= in_ready_s;
      out_valid_r <= out_valid_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_seq_chunk_adder_ctrl.sv
// Directed and randomised checks of seq_chunk_adder_ctrl at CHUNK = 8, 32 and 4.
module tb_seq_chunk_adder_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic all_done;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic        d_iv, d_ir, d_ci, d_ov, d_ordy, d_co, d_of;
  logic [31:0] d_a, d_b, d_s;

  seq_chunk_adder_ctrl #(.WIDTH(32), .CHUNK(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(d_iv), .in_ready(d_ir),
    .a(d_a), .b(d_b), .cin(d_ci), .out_valid(d_ov), .out_ready(d_ordy),
    .sum(d_s), .cout(d_co), .overflow(d_of)
  );

  // One directed operation on the CHUNK=8 instance, optionally stalled in DONE.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb2, input logic tc,
                        input logic [31:0] es, input logic ec, input logic eo, input int hold);
    @(negedge clk);
    check("idle_in_ready", 32'(d_ir), 32'd1);
    d_a = ta; d_b = tb2; d_ci = tc; d_iv = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      d_iv = 1'b0; d_a = ~ta; d_b = ~tb2; d_ci = ~tc;
      check("latency_low", 32'(d_ov), 32'd0);
    end
    @(negedge clk);
    check("out_valid", 32'(d_ov), 32'd1);
    check("sum", d_s, es);
    check("cout", 32'(d_co), 32'(ec));
    check("overflow", 32'(d_of), 32'(eo));
    check("done_in_ready", 32'(d_ir), 32'd0);
    for (int h = 0; h < hold; h++) begin
      d_iv = ~d_iv; d_a = $urandom; d_b = $urandom;
      @(negedge clk);
      check("hold_out_valid", 32'(d_ov), 32'd1);
      check("hold_sum", d_s, es);
      check("hold_cout", 32'(d_co), 32'(ec));
      check("hold_overflow", 32'(d_of), 32'(eo));
      check("hold_in_ready", 32'(d_ir), 32'd0);
    end
    d_iv = 1'b0; d_ordy = 1'b1;
    @(negedge clk);
    check("release_out_valid", 32'(d_ov), 32'd0);
    check("release_in_ready", 32'(d_ir), 32'd1);
    d_ordy = 1'b0;
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_rand
    localparam int CH = (g == 0) ? 8 : ((g == 1) ? 32 : 4);
    localparam int NC = 32 / CH;
    logic        iv, ir, ci, ov, ordy, co, of;
    logic        fin = 1'b0;
    logic [31:0] ra, rb, s;

    seq_chunk_adder_ctrl #(.WIDTH(32), .CHUNK(CH)) u_rdut (
      .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir),
      .a(ra), .b(rb), .cin(ci), .out_valid(ov), .out_ready(ordy),
      .sum(s), .cout(co), .overflow(of)
    );

    initial begin : run
      int          t, acc, last, k;
      logic [32:0] full;
      logic        eo;
      iv = 1'b0; ordy = 1'b0; ra = 32'd0; rb = 32'd0; ci = 1'b0; last = -1000;
      wait (start);
      for (int n = 0; n < 1000; n++) begin
        @(negedge clk);
        ra = $urandom; rb = $urandom; ci = 1'($urandom_range(0, 1)); iv = 1'b1;
        t = 0;
        while (!ir && t < 50) begin @(negedge clk); t++; end
        check("rand_ready_timeout", 32'(ir), 32'd1);
        acc = cyc + 1;
        check("rand_spacing", 32'((acc - last) >= (NC + 2)), 32'd1);
        last = acc;
        full = {1'b0, ra} + {1'b0, rb} + {32'd0, ci};
        eo   = (ra[31] == rb[31]) && (full[31] != ra[31]);
        @(negedge clk);
        iv = 1'b0; ra = $urandom; rb = $urandom; ci = ~ci;
        t = 0;
        while (!ov && t < 50) begin @(negedge clk); t++; end
        check("rand_latency", 32'(cyc - acc), 32'(NC));
        k = $urandom_range(0, 3);
        repeat (k) @(negedge clk);
        check("rand_out_valid", 32'(ov), 32'd1);
        check("rand_sum", s, full[31:0]);
        check("rand_cout", 32'(co), 32'(full[32]));
        check("rand_overflow", 32'(of), 32'(eo));
        ordy = 1'b1;
        @(negedge clk);
        ordy = 1'b0;
      end
      fin = 1'b1;
    end
  end

  assign all_done = g_rand[0].fin && g_rand[1].fin && g_rand[2].fin;

  initial begin
    rst_n = 1'b0; d_iv = 1'b0; d_ordy = 1'b0;
    d_a = 32'd0; d_b = 32'd0; d_ci = 1'b0;
    #12;
    check("rst_in_ready", 32'(d_ir), 32'd1);
    check("rst_out_valid", 32'(d_ov), 32'd0);
    check("rst_sum", d_s, 32'd0);
    check("rst_cout", 32'(d_co), 32'd0);
    check("rst_overflow", 32'(d_of), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 0);
    run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 0);
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 0);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 0);
    run_op(32'h00FF_00FF, 32'h0F0F_0F0F, 1'b1, 32'h100E_100F, 1'b0, 1'b0, 10);

    // Abort an operation at chunk index 2 with an asynchronous reset.
    @(negedge clk);
    d_a = 32'hFFFF_FFFF; d_b = 32'h0000_0001; d_ci = 1'b1; d_iv = 1'b1;
    @(negedge clk);
    d_iv = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("run_in_ready", 32'(d_ir), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("async_in_ready", 32'(d_ir), 32'd1);
    check("async_out_valid", 32'(d_ov), 32'd0);
    check("async_sum", d_s, 32'd0);
    check("async_cout", 32'(d_co), 32'd0);
    check("async_overflow", 32'(d_of), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 0);

    start = 1'b1;
    for (int t = 0; t < 60000 && !all_done; t++) @(negedge clk);
    check("rand_done", 32'(all_done), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
